multi_2: RTL and testbench

- Registered GF(2^8) multiply-by-2 ("xtime") unit for the AES datapath.
- Used by the MixColumns logic to form 2·b and, via 2·b ^ b, 3·b.
- Takes one byte per cycle under a valid qualifier.
- Returns the reduced product one clock later.

---
 rtl/aes_pkg.sv | 14 +
 rtl/multi_2.sv | 39 +++
 tb/tb_multi_2.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES field helpers: the reduction byte, the byte type and the
// GF(2^8) multiply-by-2 used by multi_2 and by MixColumns.
package aes_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef logic [7:0] byte_t;

  // Shift left and fold the dropped x^8 term back in as the reduction byte.
  function automatic byte_t xtime(byte_t b, byte_t poly = AES_POLY);
    return {b[6:0], 1'b0} ^ (b[7] ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/multi_2.sv
// Registered GF(2^8) multiply-by-2 (xtime): one byte per cycle in,
// reduced product out one clock later.
module multi_2
  import aes_pkg::*;
#(
  parameter byte_t POLY = AES_POLY
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in,
  output logic [7:0] out,
  output logic       out_valid
);

  byte_t w_product;
  byte_t r_out;
  logic  r_out_valid;

  assign w_product = xtime(in, POLY);

  // The data register only loads on a qualified byte, so an unknown `in`
  // during idle cycles never reaches the output and the output stays quiet.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out       <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_out <= w_product;
      end
    end
  end

  assign out       = r_out;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_multi_2.sv
// Self-checking bench for multi_2: directed steps plus random traffic, all
// compared against a generic GF(2^8) shift-and-add multiplier model.
module tb_multi_2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] inByte;
  logic [7:0] outByte;
  logic       outValid;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] expOut   = 8'h00;
  logic       expValid = 1'b0;

  always #5 clk = ~clk;

  multi_2 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in       (inByte),
    .out      (outByte),
    .out_valid(outValid)
  );

  // General field multiply modulo x^8+x^4+x^3+x+1 (0x11B).
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    int acc = 0;
    int aa  = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa << 1;
      if ((aa & 'h100) != 0) aa = aa ^ 'h11B;
    end
    return acc[7:0];
  endfunction

  // Drive one cycle's inputs, let the edge happen, update the expected state.
  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
    rst_n    = r;
    in_valid = v;
    inByte   = d;
    @(posedge clk);
    #1;
    if (!r) begin
      expOut   = 8'h00;
      expValid = 1'b0;
    end else if (v) begin
      expOut   = gfMul(d, 8'h02);
      expValid = 1'b1;
    end else begin
      expValid = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag);
    vectors++;
    assert (outByte === expOut) else begin
      miscompares++;
      $error("[TB] FAIL %s out: observed %02h expected %02h", tag, outByte, expOut);
    end
    vectors++;
    assert (outValid === expValid) else begin
      miscompares++;
      $error("[TB] FAIL %s out_valid: observed %0b expected %0b", tag, outValid, expValid);
    end
  endtask

  task automatic checkValue(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %02h expected %02h", tag, observed, expected);
    end
  endtask

  logic [7:0] redIn  [4] = '{8'h80, 8'hFF, 8'hAE, 8'h57};
  logic [7:0] redOut [4] = '{8'h1B, 8'hE5, 8'h47, 8'hAE};
  logic [7:0] strIn  [4] = '{8'h00, 8'h01, 8'h7F, 8'hC3};
  logic [7:0] strOut [4] = '{8'h00, 8'h02, 8'hFE, 8'h9D};

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    inByte   = 8'h00;

    // Reset held with a valid byte presented: nothing must come out.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 8'h2F);
      checkOutput("reset");
      checkValue("reset_out_const", outByte, 8'h00);
      checkValue("reset_valid_const", {7'd0, outValid}, 8'h00);
    end

    // First result one cycle after reset release, then idle holds it.
    applyStimulus(1'b1, 1'b1, 8'h2F);
    checkOutput("basic");
    checkValue("basic_out_const", outByte, 8'h5E);
    checkValue("basic_valid_const", {7'd0, outValid}, 8'h01);
    applyStimulus(1'b1, 1'b0, 8'hxx);
    checkOutput("idle_hold");
    checkValue("idle_hold_const", outByte, 8'h5E);
    applyStimulus(1'b1, 1'b0, 8'hA5);
    checkOutput("idle_hold2");

    // Reduction cases, each separated by an idle cycle.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, redIn[i]);
      checkOutput("reduction");
      checkValue("reduction_const", outByte, redOut[i]);
      applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("reduction_idle");
    end

    // Back-to-back stream with no bubbles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, strIn[i]);
      checkOutput("stream");
      checkValue("stream_const", outByte, strOut[i]);
    end

    // Exhaustive sweep, back-to-back.
    for (int b = 0; b < 256; b++) begin
      applyStimulus(1'b1, 1'b1, 8'(b));
      checkOutput("sweep");
    end

    // 3*b formed as 2*b ^ b.
    applyStimulus(1'b1, 1'b1, 8'h57);
    checkValue("mul3_model", outByte ^ 8'h57, gfMul(8'h57, 8'h03));
    checkValue("mul3_fips", outByte ^ 8'h57, 8'hF9);

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)), 8'($urandom));
      checkOutput("random");
    end

    // Reset on the same edge as a valid 0x80: the 0x1B must never appear.
    applyStimulus(1'b1, 1'b1, 8'h3C);
    checkOutput("pre_midreset");
    applyStimulus(1'b0, 1'b1, 8'h80);
    checkOutput("midreset");
    checkValue("midreset_out_const", outByte, 8'h00);
    applyStimulus(1'b1, 1'b0, 8'h80);
    checkOutput("post_midreset");
    checkValue("post_midreset_const", outByte, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
